// File: rtl/bus_mem_responder_if.sv
// Request/response bus between an initiator and the memory responder.
// The initiator drives req/we/bus_din; the responder drives everything else.
interface bus_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] bus_din;
    logic [31:0] bus_dout;
    logic        bus_dout_en;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, we, bus_din,
        input  bus_dout, bus_dout_en, ready, busy, err
    );

    modport slave (
        input  req, we, bus_din,
        output bus_dout, bus_dout_en, ready, busy, err
    );
endinterface

// File: rtl/bus_mem_responder.sv
// Single-port 32-bit word memory behind a req/ready bus.
// Each accepted request runs IDLE -> (WAIT) -> RESP -> IDLE.
// Misaligned or out-of-range addresses complete with err and never touch memory.
module bus_mem_responder #(
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter bit          INIT_ZERO   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_mem_responder_if.slave     bus_io
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // State taken on an accepted request: skip WAIT entirely when there are no wait states.
    localparam state_e     StAfterReq = (WAIT_STATES > 0) ? StWait : StResp;
    localparam logic [3:0] CntLoad    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] InitWord  = INIT_ZERO ? 32'h0 : 32'hx;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q;
    logic          req_err;
    logic          rd_en;
    logic          wr_en;

    // Contents are set once at time zero; reset never clears them.
    logic [31:0] mem_q [Depth] = '{default: InitWord};

    // Misaligned or any address bit above the word index set means error.
    always_comb begin
        req_err = (bus_io.bus_din[1:0] != 2'b00) || ((bus_io.bus_din >> (AW + 2)) != 32'h0);
    end

    // Next-state logic: request capture, wait countdown, single-cycle response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.req) begin
                    idx_d   = bus_io.bus_din[AW+1:2];
                    we_d    = bus_io.we;
                    err_d   = req_err;
                    cnt_d   = CntLoad;
                    state_d = StAfterReq;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read on the edge entering RESP; write on the edge leaving it.
    always_comb begin
        rd_en = (state_d == StResp) && (state_q != StResp) && !we_d;
        wr_en = (state_q == StResp) && we_q && !err_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Memory array plus registered read data; reset blocks a pending write.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[idx_q] <= bus_io.bus_din;
        end
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (rd_en) begin
            rdata_q <= err_d ? 32'h0 : mem_q[idx_d];
        end
    end

    // Bus outputs are only active during RESP.
    always_comb begin
        bus_io.ready       = (state_q == StResp);
        bus_io.err         = (state_q == StResp) && err_q;
        bus_io.busy        = (state_q != StIdle);
        bus_io.bus_dout_en = (state_q == StResp) && !we_q;
        bus_io.bus_dout    = bus_io.bus_dout_en ? rdata_q : 32'h0;
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: three instances with 0, 1 and 3 wait states.
module tb_bus_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Index 0: WAIT_STATES=0, 1: WAIT_STATES=1, 2: WAIT_STATES=3
    logic        req_v  [3];
    logic        we_v   [3];
    logic [31:0] din_v  [3];
    logic        rdy_v  [3];
    logic        err_v  [3];
    logic        busy_v [3];
    logic        den_v  [3];
    logic [31:0] dout_v [3];

    bus_mem_responder_if if_a ();
    bus_mem_responder_if if_b ();
    bus_mem_responder_if if_c ();

    assign if_a.req = req_v[0];  assign if_a.we = we_v[0];  assign if_a.bus_din = din_v[0];
    assign if_b.req = req_v[1];  assign if_b.we = we_v[1];  assign if_b.bus_din = din_v[1];
    assign if_c.req = req_v[2];  assign if_c.we = we_v[2];  assign if_c.bus_din = din_v[2];

    assign rdy_v[0] = if_a.ready;  assign err_v[0] = if_a.err;  assign busy_v[0] = if_a.busy;
    assign den_v[0] = if_a.bus_dout_en;  assign dout_v[0] = if_a.bus_dout;
    assign rdy_v[1] = if_b.ready;  assign err_v[1] = if_b.err;  assign busy_v[1] = if_b.busy;
    assign den_v[1] = if_b.bus_dout_en;  assign dout_v[1] = if_b.bus_dout;
    assign rdy_v[2] = if_c.ready;  assign err_v[2] = if_c.err;  assign busy_v[2] = if_c.busy;
    assign den_v[2] = if_c.bus_dout_en;  assign dout_v[2] = if_c.bus_dout;

    bus_mem_responder #(.AW(10), .WAIT_STATES(0), .INIT_ZERO(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus_io(if_a.slave)
    );
    bus_mem_responder #(.AW(10), .WAIT_STATES(1), .INIT_ZERO(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus_io(if_b.slave)
    );
    bus_mem_responder #(.AW(10), .WAIT_STATES(3), .INIT_ZERO(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus_io(if_c.slave)
    );

    logic [31:0] model [1024];

    function automatic int ws_of(input int s);
        case (s)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction starting at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic txn(input int s, input logic w, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic pulse, input logic exp_err,
                       input logic [31:0] exp_rd, input string tag);
        int lat;
        req_v[s] = 1'b1;  we_v[s] = w;  din_v[s] = addr;
        @(negedge clk);
        req_v[s] = pulse;  we_v[s] = 1'b0;  din_v[s] = wdata;
        lat = 1;
        while (!rdy_v[s] && lat < 40) begin
            check({tag, " busy"}, 32'(busy_v[s]), 32'd1);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(ws_of(s) + 1));
        check({tag, " err"}, 32'(err_v[s]), 32'(exp_err));
        check({tag, " dout_en"}, 32'(den_v[s]), 32'(!w));
        check({tag, " dout"}, dout_v[s], w ? 32'h0 : exp_rd);
        @(negedge clk);
        req_v[s] = 1'b0;
        check({tag, " ready after"}, 32'(rdy_v[s]), 32'd0);
        check({tag, " busy after"}, 32'(busy_v[s]), 32'd0);
    endtask

    initial begin
        int          word;
        int          kind;
        logic        w;
        logic        pulse;
        logic        e;
        logic [31:0] addr;
        logic [31:0] wdata;

        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1'b0;  we_v[i] = 1'b0;  din_v[i] = 32'h0;
        end

        // Reset, with a write request held on instance 1 that must be ignored.
        rst = 1'b1;
        req_v[1] = 1'b1;  we_v[1] = 1'b1;  din_v[1] = 32'h10;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req_v[1] = 1'b0;  we_v[1] = 1'b0;  din_v[1] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("reset ready", 32'(rdy_v[i]), 32'd0);
            check("reset err", 32'(err_v[i]), 32'd0);
            check("reset busy", 32'(busy_v[i]), 32'd0);
            check("reset dout_en", 32'(den_v[i]), 32'd0);
            check("reset dout", dout_v[i], 32'h0);
        end
        @(negedge clk);
        check("reset busy later", 32'(busy_v[1]), 32'd0);

        // Basic write then read, one wait state.
        txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, "ws1 wr10");
        txn(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, "ws1 rd10");

        // Back-to-back reads with zero wait states; req held during RESP must be dropped.
        txn(0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 32'h0, "ws0 wr0");
        txn(0, 1'b1, 32'h4, 32'h2222_2222, 1'b0, 1'b0, 32'h0, "ws0 wr4");
        txn(0, 1'b1, 32'h8, 32'h3333_3333, 1'b0, 1'b0, 32'h0, "ws0 wr8");
        req_v[0] = 1'b1;  we_v[0] = 1'b0;  din_v[0] = 32'h0;
        @(negedge clk);
        check("b2b ready0", 32'(rdy_v[0]), 32'd1);
        check("b2b dout0", dout_v[0], 32'h1111_1111);
        din_v[0] = 32'h8;
        @(negedge clk);
        check("b2b gap ready", 32'(rdy_v[0]), 32'd0);
        check("b2b gap busy", 32'(busy_v[0]), 32'd0);
        din_v[0] = 32'h4;
        @(negedge clk);
        check("b2b ready1", 32'(rdy_v[0]), 32'd1);
        check("b2b dout1", dout_v[0], 32'h2222_2222);
        req_v[0] = 1'b0;
        @(negedge clk);
        check("b2b end ready", 32'(rdy_v[0]), 32'd0);
        check("b2b end busy", 32'(busy_v[0]), 32'd0);

        // Error cases leave memory untouched; top word is a valid address.
        txn(1, 1'b1, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, "err wr0");
        txn(1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 32'h0, "err rd13");
        txn(1, 1'b1, 32'h1000, 32'hBAD0_BAD0, 1'b0, 1'b1, 32'h0, "err wr1000");
        txn(1, 1'b1, 32'h2, 32'hBAD1_BAD1, 1'b0, 1'b1, 32'h0, "err wr2");
        txn(1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 32'h0, "err rdhi");
        txn(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFE_F00D, "err rd0");
        txn(1, 1'b1, 32'hFFC, 32'h5A5A_A5A5, 1'b0, 1'b0, 32'h0, "top wr");
        txn(1, 1'b0, 32'hFFC, 32'h0, 1'b0, 1'b0, 32'h5A5A_A5A5, "top rd");

        // Reset during WAIT of a write aborts it.
        txn(1, 1'b1, 32'h20, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0, "abort pre");
        req_v[1] = 1'b1;  we_v[1] = 1'b1;  din_v[1] = 32'h20;
        @(negedge clk);
        check("abort wait busy", 32'(busy_v[1]), 32'd1);
        req_v[1] = 1'b0;  we_v[1] = 1'b0;  din_v[1] = 32'h1234_5678;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", 32'(rdy_v[1]), 32'd0);
        check("abort busy", 32'(busy_v[1]), 32'd0);
        @(negedge clk);
        check("abort ready later", 32'(rdy_v[1]), 32'd0);
        txn(1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'hAAAA_5555, "abort rd20");

        // Reset during RESP of a write blocks the memory update.
        txn(1, 1'b1, 32'h24, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h0, "rstresp pre");
        req_v[1] = 1'b1;  we_v[1] = 1'b1;  din_v[1] = 32'h24;
        @(negedge clk);
        req_v[1] = 1'b0;  we_v[1] = 1'b0;  din_v[1] = 32'h8765_4321;
        @(negedge clk);
        check("rstresp ready", 32'(rdy_v[1]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstresp busy", 32'(busy_v[1]), 32'd0);
        txn(1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0F0F_0F0F, "rstresp rd24");

        // Random traffic on the 3-wait-state instance against a word model.
        for (int n = 0; n < 100; n++) begin
            word = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) word = 1023;
            addr = 32'(word) << 2;
            kind = $urandom_range(0, 9);
            if (kind == 0) addr = addr | 32'($urandom_range(1, 3));
            else if (kind == 1) addr = addr | (32'h1 << $urandom_range(12, 31));
            e     = (kind < 2);
            w     = 1'($urandom_range(0, 1));
            pulse = 1'($urandom_range(0, 1));
            wdata = $urandom();
            txn(2, w, addr, wdata, pulse, e, (w || e) ? 32'h0 : model[word], "rnd");
            if (w && !e) model[word] = wdata;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter AW, default 10, word-address width; memory depth 2**AW 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, range 0..15, extra cycles inserted between request and response.
REQ-003 Parameter INIT_ZERO, default 1; 1 means memory contents are all zero at time 0 (not affected by reset).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  1  initiator request strobe; address present on bus_din this cycle.
REQ-007 we  input  1  write when 1, read when 0; sampled with req.
REQ-008 bus_din  input  32  shared databus as seen by responder: byte address in request cycle, write data in response cycle.
REQ-009 bus_dout  output  32  read data toward databus.
REQ-010 bus_dout_en  output  1  responder drives databus this cycle (read response only).
REQ-011 ready  output  1  one-cycle response strobe ending a transaction.
REQ-012 busy  output  1  transaction in progress; new req ignored.
REQ-013 err  output  1  one-cycle error strobe, coincident with ready.

Function
REQ-014 States: IDLE, WAIT, RESP; encoded state register; no other reachable states.
REQ-015 IDLE, req=1 at edge E0: latch addr=bus_din, we; next state WAIT if WAIT_STATES>0, else RESP.
REQ-016 IDLE, req=0: remain IDLE, all strobes 0.
REQ-017 WAIT: down-counter loaded with WAIT_STATES-1 at E0; decrement each edge; go RESP at the edge where it reads 0.
REQ-018 RESP lasts exactly one cycle, then IDLE; ready=1 only in RESP, so ready rises WAIT_STATES+1 cycles after E0.
REQ-019 busy=1 in WAIT and RESP; req asserted while busy is ignored, not queued.
REQ-020 req in the cycle immediately after RESP (state IDLE) is accepted; back-to-back throughput one transaction per WAIT_STATES+2 cycles.
REQ-021 Word index = addr[AW+1:2]; byte lanes not supported, full 32-bit access only.
REQ-022 Error when addr[1:0]!=0 (misaligned) or addr[31:AW+2]!=0 (out of range); checked at E0.
REQ-023 Error transaction: RESP with ready=1, err=1, bus_dout=0, bus_dout_en=1 for reads, no memory write.
REQ-024 Read: memory read synchronously on the edge entering RESP; bus_dout valid and bus_dout_en=1 throughout RESP.
REQ-025 Write: bus_din sampled and written to memory at the edge ending RESP; bus_dout_en=0 for writes.
REQ-026 Outside RESP: bus_dout=0, bus_dout_en=0, ready=0, err=0.
REQ-027 Read of a word written by the immediately preceding transaction returns the new value.
REQ-028 Address wrap is not permitted; out-of-range addresses never alias to in-range words.

Reset
REQ-029 rst=1 at an edge: state=IDLE, counter=0, latched addr=0, we=0; next cycle ready=0, err=0, busy=0, bus_dout_en=0, bus_dout=0.
REQ-030 rst mid-transaction (WAIT or RESP) aborts it: no ready, no err, no memory write at that edge.
REQ-031 req while rst=1 is ignored; memory contents unchanged by reset.

Verification
REQ-032 WAIT_STATES=1: write req addr=0x0000_0010, data 0xDEAD_BEEF in response cycle; then read 0x10 -> ready 2 cycles after each req, bus_dout=0xDEADBEEF, bus_dout_en=1, err=0.
REQ-033 WAIT_STATES=0: back-to-back reads 0x0, 0x4 with req in every IDLE cycle -> ready every 2nd cycle, data per word; req during RESP ignored.
REQ-034 Read addr=0x0000_0013 -> ready=1, err=1, bus_dout=0; write addr=0x0000_1000 (AW=10) -> err=1, no word modified (read 0x0 still prior value).
REQ-035 rst asserted in WAIT of a write to 0x20 (data 0x1234_5678) -> no ready, busy=0 after reset, subsequent read 0x20 returns old value.
REQ-036 req pulsed while busy=1 -> no extra ready; exactly one ready per accepted req over 100 random transactions checked against a reference model.
